// File: rtl/flat_shader_pipe.sv
// Four-stage flat Lambert shader: edge vectors, face normal, n.L, then cull/saturate/scale.
// A single global advance enable moves every stage together, so a stalled output freezes the whole pipe.
module flat_shader_pipe #(
  parameter int COORD_W = 16,
  parameter int LIGHT_W = 8,
  parameter int COLOR_W = 8,
  parameter int NUM_CH  = 3,
  parameter int SHIFT   = 0,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             data_valid_in,
  output logic                             ready_out,
  input  logic [2:0][2:0][COORD_W-1:0]     triangle,
  input  logic [2:0][LIGHT_W-1:0]          light,
  input  logic [NUM_CH-1:0][COLOR_W-1:0]   base_color,
  input  logic [TAG_W-1:0]                 tag_in,
  output logic                             valid_out,
  input  logic                             ready_in,
  output logic [NUM_CH-1:0][COLOR_W-1:0]   color_out,
  output logic                             culled_out,
  output logic [TAG_W-1:0]                 tag_out,
  output logic [CNT_W-1:0]                 shaded_cnt,
  output logic [CNT_W-1:0]                 culled_cnt
);
  localparam int E_W = COORD_W + 1;
  localparam int N_W = 2 * COORD_W + 3;
  localparam int D_W = N_W + LIGHT_W + 2;

  logic adv;
  logic out_xfer;

  assign adv       = !valid_out || ready_in;
  assign ready_out = adv;
  assign out_xfer  = valid_out && ready_in;

  // Operands are widened before multiplying so the product is exact at the target width.
  function automatic logic signed [N_W-1:0] mul_n(input logic signed [E_W-1:0] a,
                                                  input logic signed [E_W-1:0] b);
    logic signed [N_W-1:0] ax;
    logic signed [N_W-1:0] bx;
    ax = N_W'(a);
    bx = N_W'(b);
    return ax * bx;
  endfunction

  function automatic logic signed [D_W-1:0] mul_d(input logic signed [N_W-1:0] n,
                                                  input logic signed [LIGHT_W-1:0] l);
    logic signed [D_W-1:0] nx;
    logic signed [D_W-1:0] lx;
    nx = D_W'(n);
    lx = D_W'(l);
    return nx * lx;
  endfunction

  logic                           s1_valid;
  logic signed [E_W-1:0]          s1_e1 [3];
  logic signed [E_W-1:0]          s1_e2 [3];
  logic [2:0][LIGHT_W-1:0]        s1_light;
  logic [NUM_CH-1:0][COLOR_W-1:0] s1_base;
  logic [TAG_W-1:0]               s1_tag;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        s1_e1[i] <= '0;
        s1_e2[i] <= '0;
      end
      s1_light <= '0;
      s1_base  <= '0;
      s1_tag   <= '0;
    end else if (adv) begin
      s1_valid <= data_valid_in;
      for (int i = 0; i < 3; i++) begin
        s1_e1[i] <= E_W'($signed(triangle[1][i])) - E_W'($signed(triangle[0][i]));
        s1_e2[i] <= E_W'($signed(triangle[2][i])) - E_W'($signed(triangle[0][i]));
      end
      s1_light <= light;
      s1_base  <= base_color;
      s1_tag   <= tag_in;
    end
  end

  logic                           s2_valid;
  logic signed [N_W-1:0]          s2_n [3];
  logic [2:0][LIGHT_W-1:0]        s2_light;
  logic [NUM_CH-1:0][COLOR_W-1:0] s2_base;
  logic [TAG_W-1:0]               s2_tag;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s2_valid <= 1'b0;
      for (int i = 0; i < 3; i++) s2_n[i] <= '0;
      s2_light <= '0;
      s2_base  <= '0;
      s2_tag   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_n[0]  <= mul_n(s1_e1[1], s1_e2[2]) - mul_n(s1_e1[2], s1_e2[1]);
      s2_n[1]  <= mul_n(s1_e1[2], s1_e2[0]) - mul_n(s1_e1[0], s1_e2[2]);
      s2_n[2]  <= mul_n(s1_e1[0], s1_e2[1]) - mul_n(s1_e1[1], s1_e2[0]);
      s2_light <= s1_light;
      s2_base  <= s1_base;
      s2_tag   <= s1_tag;
    end
  end

  logic                           s3_valid;
  logic signed [D_W-1:0]          s3_d;
  logic [NUM_CH-1:0][COLOR_W-1:0] s3_base;
  logic [TAG_W-1:0]               s3_tag;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s3_valid <= 1'b0;
      s3_d     <= '0;
      s3_base  <= '0;
      s3_tag   <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_d     <= mul_d(s2_n[0], s2_light[0]) + mul_d(s2_n[1], s2_light[1])
                + mul_d(s2_n[2], s2_light[2]);
      s3_base  <= s2_base;
      s3_tag   <= s2_tag;
    end
  end

  logic                           d_pos;
  logic signed [D_W-1:0]          d_shift;
  logic [COLOR_W-1:0]             intensity;
  logic [2*COLOR_W:0]             prod;
  logic [NUM_CH-1:0][COLOR_W-1:0] color_c;

  assign d_pos     = !s3_d[D_W-1] && (s3_d != '0);
  assign d_shift   = s3_d >>> SHIFT;
  assign intensity = (|d_shift[D_W-1:COLOR_W]) ? '1 : d_shift[COLOR_W-1:0];

  // Scaling by (base+1) lets full intensity with base=max return exactly max.
  always_comb begin
    color_c = '0;
    prod    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      prod       = (2*COLOR_W+1)'(intensity)
                 * ((2*COLOR_W+1)'(s3_base[k]) + (2*COLOR_W+1)'(1));
      color_c[k] = COLOR_W'(prod >> COLOR_W);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_out  <= 1'b0;
      color_out  <= '0;
      culled_out <= 1'b0;
      tag_out    <= '0;
    end else if (adv) begin
      valid_out  <= s3_valid;
      color_out  <= d_pos ? color_c : '0;
      culled_out <= !d_pos;
      tag_out    <= s3_tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      shaded_cnt <= '0;
      culled_cnt <= '0;
    end else if (out_xfer) begin
      if (culled_out) begin
        if (culled_cnt != '1) culled_cnt <= culled_cnt + CNT_W'(1);
      end else begin
        if (shaded_cnt != '1) shaded_cnt <= shaded_cnt + CNT_W'(1);
      end
    end
  end

endmodule
